// File: rtl/serial_rotate_right.sv
// serial_rotate_right: multi-cycle rotate-right unit that undoes a barrel
// shifter's rotate-left. A captured word moves one bit position per clock
// until the requested distance is used up. The result is then held until
// downstream takes it. Valid/ready handshakes are used on both sides.
module serial_rotate_right #(
  parameter int WIDTH = 10,
  parameter int SHW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SHW-1:0]   shift_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [SHW-1:0] count;

  // Rotate right by a single position: the LSB wraps around into the MSB.
  function automatic logic [WIDTH-1:0] rotr1(input logic [WIDTH-1:0] x);
    return {x[0], x[WIDTH-1:1]};
  endfunction

  // Registered state, working word and remaining-distance counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      data_out <= '0;
      count    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_out <= data_in;
            count    <= shift_amt;
          end
        end
        SHIFT: begin
          if (count != '0) begin
            data_out <= rotr1(data_out);
            count    <= count - SHW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next state. Leaving DONE always passes through IDLE, so a new request
  // cannot be accepted in the same cycle that the result is consumed.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)      state_nxt = SHIFT;
      SHIFT:   if (count == '0)   state_nxt = DONE;
      DONE:    if (out_ready)     state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: doc/serial_rotate_right.md
Name: serial_rotate_right

Overview:
- Multi-cycle inverse of the combinational 10-bit barrel shifter.
- Rotates a captured word RIGHT by shift_amt positions, one bit position per clock. Feeding it the shifter's output with the same shift_amt restores the shifter's input.
- Sits downstream of the barrel shifter, behind a valid/ready handshake on both sides.

Parameters:
- WIDTH, 10, data word width in bits.
- SHW, 3, shift-amount width in bits. Constraint: 2**SHW <= WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream presents data_in and shift_amt.
- in_ready  output  1  block accepts a request this cycle.
- data_in  input  WIDTH  word to un-shift.
- shift_amt  input  SHW  rotate-right distance.
- out_valid  output  1  data_out holds a finished result.
- out_ready  input  1  downstream consumes the result.
- data_out  output  WIDTH  working/result register.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset (rst_n low, asynchronous, dominant at any time including mid-operation):
  - state=IDLE; data_out=0; count=0.
  - in_ready=1 after release; out_valid=0; busy=0.
  - Any in-flight request is discarded.
- FSM states IDLE, SHIFT, DONE. in_ready=(state==IDLE); out_valid=(state==DONE); busy=!in_ready. All outputs are registered or direct decodes of the state register.
- IDLE:
  - on in_valid&&in_ready: data_out<=data_in, count<=shift_amt, go SHIFT.
  - Otherwise hold. data_out keeps its last value.
- SHIFT:
  - if count!=0: data_out<={data_out[0], data_out[WIDTH-1:1]}, count<=count-1, stay.
  - if count==0: go DONE, no rotation.
- DONE:
  - hold data_out stable.
  - on out_ready: go IDLE. in_ready rises in the cycle after the handshake; no same-cycle accept.
- Latency: the accepting edge is E. out_valid is high after edge E+shift_amt+1.
  - shift_amt=0 -> 1 cycle, output equals input.
  - shift_amt=7 -> 8 cycles.
- Inputs are sampled only at the accepting edge. Changes to data_in, shift_amt or in_valid while busy are ignored.
- out_ready while not in DONE is ignored.
- out_ready held high before DONE: DONE is entered, out_valid is high for exactly 1 cycle, then IDLE.
- Backpressure: out_ready low holds DONE and data_out indefinitely.
- Rotation is pure rotate, modulo WIDTH. No bits are lost and no fill value is used.

Test Plan:
- Reset mid-shift: accept 10'b0001101001 with shift 5, then pull rst_n low after 2 cycles (asynchronously, off a clock edge) -> immediately data_out=0, out_valid=0, busy=0; after release in_ready=1.
- Zero shift: data_in=10'b0001101001, shift_amt=0, out_ready=1 -> out_valid high 1 cycle after accept, data_out=10'b0001101001, in_ready back 2 cycles after accept.
- Inverse check: data_in=10'b1101001000 (0001101001 rotated left 3), shift_amt=3 -> after 4 cycles out_valid=1, data_out=10'b0001101001.
- Sweep: data_in=10'b0001101001, shift_amt 0..7 sequentially with out_ready=1 -> results are 0001101001, 1000110100, 0100011010, 0010001101, 1001000110, 0100100011, 1010010001, 1101001000; each latency is shift_amt+1 cycles.
- Backpressure: shift_amt=7, out_ready=0 for 10 cycles -> out_valid and data_out=10'b1101001000 stable and in_ready=0 throughout; raise out_ready -> IDLE next cycle.
- Ignored inputs: while busy, toggle data_in to 10'h3FF and keep in_valid=1 -> result unaffected; second request accepted only when in_ready=1.
